// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters: registered one-hot grant plus index, held until release.
// Optional forced-release hold timer is compiled in with `define RR_ARBITER8_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | no grant active; arbitrate req from ptr each cycle
// ST_GRANT | one requester owns the resource until done, req drop or timeout
module rr_arbiter8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_vld,
   output logic       timeout
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   logic [0:0] state;
   logic [2:0] ptr;
   logic       win_found;
   logic [2:0] win_idx;
   logic [2:0] cand;
   logic       rel_req;
   logic       force_rel;
   logic       release_now;

   // Scan req starting at ptr, wrapping mod 8; first set bit wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      cand      = 3'd0;
      for (int k = 0; k < 8; k++) begin
         cand = ptr + 3'(k);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign rel_req     = done | ~req[gnt_idx];
   assign release_now = rel_req | force_rel;

`ifdef RR_ARBITER8_TIMEOUT_EN
   localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

   logic [HOLD_W-1:0] hold_cnt;

   // Counter reads k-1 during the k-th grant cycle, so the last legal edge sees MAX_HOLD-1.
   assign force_rel = (state == ST_GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
      end else if (state == ST_GRANT && !release_now) begin
         hold_cnt <= hold_cnt + 1'b1;
      end else begin
         hold_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout <= 1'b0;
      end else begin
         timeout <= force_rel & ~rel_req;
      end
   end
`else
   localparam int unused_max_hold = MAX_HOLD;

   assign force_rel = 1'b0;
   assign timeout   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         ptr     <= 3'd0;
         gnt     <= 8'd0;
         gnt_idx <= 3'd0;
         gnt_vld <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_found) begin
                  gnt     <= 8'd1 << win_idx;
                  gnt_idx <= win_idx;
                  gnt_vld <= 1'b1;
                  state   <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (release_now) begin
                  gnt     <= 8'd0;
                  gnt_idx <= 3'd0;
                  gnt_vld <= 1'b0;
                  ptr     <= gnt_idx + 3'd1;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, rotation, wrap, req-drop release, async reset, hold timeout.
module tb_rr_arbiter8;

   localparam int MAX_HOLD = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;

   int n_checks = 0;
   int n_fail   = 0;

   rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] idx,
                             input logic vld, input logic tmo);
      check({tag, ".gnt"}, 32'(gnt), 32'(g));
      check({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
      check({tag, ".vld"}, 32'(gnt_vld), 32'(vld));
      check({tag, ".tmo"}, 32'(timeout), 32'(tmo));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 8'h00;
      done  = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset with every requester asking
      rst_n = 1'b0;
      req   = 8'hFF;
      done  = 1'b0;
      #3;
      expect_out("rst_now", 8'h00, 3'd0, 1'b0, 1'b0);
      step();
      step();
      expect_out("rst_held", 8'h00, 3'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step();
      expect_out("rst_first", 8'h01, 3'd0, 1'b1, 1'b0);

      // Rotation between requesters 0 and 2, done kept high (also ignored in idle)
      do_reset();
      req = 8'b0000_0101;
      step();
      expect_out("rot_g0", 8'h01, 3'd0, 1'b1, 1'b0);
      done = 1'b1;
      step();
      expect_out("rot_idle0", 8'h00, 3'd0, 1'b0, 1'b0);
      step();
      expect_out("rot_g2", 8'h04, 3'd2, 1'b1, 1'b0);
      step();
      expect_out("rot_idle1", 8'h00, 3'd0, 1'b0, 1'b0);
      step();
      expect_out("rot_g0b", 8'h01, 3'd0, 1'b1, 1'b0);

      // Wrap: ptr reaches 7, then 7 beats 0, then 0 after wrap
      do_reset();
      req = 8'b0100_0000;
      step();
      expect_out("wrap_g6", 8'h40, 3'd6, 1'b1, 1'b0);
      done = 1'b1;
      step();
      expect_out("wrap_rel6", 8'h00, 3'd0, 1'b0, 1'b0);
      done = 1'b0;
      req  = 8'b1000_0001;
      step();
      expect_out("wrap_g7", 8'h80, 3'd7, 1'b1, 1'b0);
      done = 1'b1;
      step();
      expect_out("wrap_rel7", 8'h00, 3'd0, 1'b0, 1'b0);
      done = 1'b0;
      step();
      expect_out("wrap_g0", 8'h01, 3'd0, 1'b1, 1'b0);

      // Holder 3 keeps grant while others change, then releases by dropping req[3]
      do_reset();
      req = 8'b0000_1000;
      step();
      expect_out("drop_g3", 8'h08, 3'd3, 1'b1, 1'b0);
      req = 8'b1010_1011;
      step();
      expect_out("drop_hold", 8'h08, 3'd3, 1'b1, 1'b0);
      req = 8'b0010_0011;
      step();
      expect_out("drop_rel", 8'h00, 3'd0, 1'b0, 1'b0);
      step();
      expect_out("drop_g5", 8'h20, 3'd5, 1'b1, 1'b0);

      // Asynchronous reset while 5 is held; ptr returns to 0
      do_reset();
      req = 8'b0010_0000;
      step();
      expect_out("arst_g5", 8'h20, 3'd5, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      expect_out("arst_now", 8'h00, 3'd0, 1'b0, 1'b0);
      req = 8'b0010_0001;
      step();
      rst_n = 1'b1;
      step();
      expect_out("arst_g0", 8'h01, 3'd0, 1'b1, 1'b0);

      // Hold limit with requester 1 never releasing
      do_reset();
      req = 8'b0000_0010;
      step();
      expect_out("hold_g1", 8'h02, 3'd1, 1'b1, 1'b0);
`ifdef RR_ARBITER8_TIMEOUT_EN
      for (int i = 2; i <= MAX_HOLD; i++) begin
         step();
         expect_out($sformatf("tmo_c%0d", i), 8'h02, 3'd1, 1'b1, 1'b0);
      end
      step();
      expect_out("tmo_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
      step();
      expect_out("tmo_regnt", 8'h02, 3'd1, 1'b1, 1'b0);
`else
      for (int i = 2; i <= 21; i++) begin
         step();
         expect_out($sformatf("hold_c%0d", i), 8'h02, 3'd1, 1'b1, 1'b0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter and grant sequencer for eight requesters sharing one resource. Each cycle it resolves the `req` vector into a registered one-hot grant and its 3-bit binary index. It holds the grant until the winner releases, then rotates priority. It sits in front of the 8-to-3 encoding datapath and replaces raw `en`/`in` driving with a sequenced, fair grant stream.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant may be held; used only when the timeout feature is compiled in; legal range ≥ 2.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 8: request vector; bit i = requester i.
- `done` in 1: current holder releases the resource; ignored when no grant is active.
- `gnt` out 8: registered one-hot grant; all zero when idle.
- `gnt_idx` out 3: binary index of the granted bit (bit i → i); 3'b000 when `gnt_vld`=0.
- `gnt_vld` out 1: high while a grant is active.
- `timeout` out 1: one-cycle pulse on a forced release; constant 0 when the feature is compiled out.

## Operation
- Two states:
  - IDLE: no grant active.
  - GRANT: one requester owns the resource.
- Internal 3-bit priority pointer `ptr`. It names the highest-priority requester for the next arbitration.
- IDLE, `req`≠0:
  - Winner w is the first set bit scanning `req[ptr]`, `req[ptr+1]`, … mod 8.
  - Registers set: `gnt`=1<<w, `gnt_idx`=w, `gnt_vld`=1.
  - Next state GRANT.
- IDLE, `req`=0: outputs stay zero; `ptr` unchanged.
- GRANT: release when `done`=1 or `req[w]`=0 (either condition suffices). On release:
  - `gnt`, `gnt_idx`, `gnt_vld` clear.
  - `ptr` ← (w+1) mod 8; wrap 7→0.
  - Next state IDLE.
- GRANT, no release: all outputs and `ptr` hold. Changes to other `req` bits have no effect.
- `gnt` is always one-hot or zero. `gnt_idx` always equals the encoded `gnt`.
- Reset values: `gnt`=0, `gnt_idx`=0, `gnt_vld`=0, `timeout`=0, `ptr`=0, state IDLE, hold counter 0.
- Reset asserted mid-grant: outputs clear immediately (asynchronously). No release is recorded and `ptr` returns to 0.

## Timing
- Grant latency:
  - `req` sampled nonzero at edge N in IDLE → grant outputs valid after edge N.
  - Combinational path is req → registered outputs only; no combinational path from `req` to any output.
- Release latency: `done`=1 or `req[w]`=0 sampled at edge M → outputs cleared after edge M.
- The first possible re-arbitration is at edge M+1, so there is exactly one idle cycle between consecutive grants.
- Minimum grant length is 1 cycle: `done` already high at the first GRANT edge releases at that edge.
- A `done` pulse while in IDLE is ignored and is not stored.

## Configuration
- Macro: `RR_ARBITER8_TIMEOUT_EN`.
- Defined:
  - A hold counter clears on entry to GRANT and increments each GRANT cycle.
  - If no release occurs by the MAX_HOLD-th GRANT cycle, that edge forces a release; `gnt_vld` is high for exactly MAX_HOLD cycles.
  - A forced release rotates `ptr` exactly as a normal release does and pulses `timeout` for one cycle.
  - A normal release on that same edge takes precedence: `timeout` stays 0.
- Undefined: no counter logic; `timeout` is tied to 0; grants are held indefinitely.

## Test plan
- Reset: assert `rst_n`=0 with `req`=8'hFF → `gnt`=0, `gnt_idx`=0, `gnt_vld`=0, `timeout`=0; deassert → first grant goes to requester 0.
- Rotation: `req`=8'b0000_0101 held, `done` pulsed each grant → grants 00000001/idx 0, then 00000100/idx 2, then 00000001/idx 0, with one idle cycle between grants.
- Wrap: `req`=8'b0100_0000, release → `ptr`=7; then `req`=8'b1000_0001 → grant idx 7 first, then idx 0.
- Drop release: holder idx 3 deasserts `req[3]` without `done` → `gnt_vld` low after that edge; next grant goes to the lowest-indexed set bit ≥ 4 (mod 8).
- Reset mid-grant: `rst_n` low while idx 5 is held → outputs zero immediately; after release with `req`=8'b0010_0001 → grant idx 0.
- Timeout (macro defined, MAX_HOLD=4): `req`=8'b0000_0010 held, `done`=0 → `gnt_vld` high exactly 4 cycles, `timeout` pulses 1 cycle, idle 1 cycle, then idx 1 is re-granted; without the macro the grant is held for ≥ 20 cycles.
